// File: rtl/dnoc_out_arb_pkg.sv
// Shared types for the DNoC interface output arbiter: FSM state encoding,
// node-id type and the default-width sync-target type.
package dnoc_out_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_SEND = 2'd2
    } arb_state_e;

    localparam int NODE_ID_W  = 4;
    localparam int SYNC_W_DEF = 12;

    typedef logic [NODE_ID_W-1:0]  node_id_t;
    typedef logic [SYNC_W_DEF-1:0] sync_target_t;

endpackage

// File: rtl/dnoc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N; returns the winner one-hot and as an index.
module dnoc_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    // scan from ptr upward; the first hit wins and masks all later ones
    always_comb begin
        logic [PTR_W-1:0] pos_s;
        logic             hit_s;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos_s  = '0;
        hit_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s         = PTR_W'((int'(ptr) + k) % N);
            hit_s         = req[pos_s] & ~any;
            onehot[pos_s] = onehot[pos_s] | hit_s;
            idx           = hit_s ? pos_s : idx;
            any           = any | hit_s;
        end
    end

endmodule

// File: rtl/dnoc_itf_out_arb.sv
// DNoC interface output arbiter: round-robin over channels, optional barrier
// sync for locally owned multicast, single-flit injection. Define
// DNOC_OUT_ARB_SYNC_TIMEOUT_EN to bound the sync wait with TIMEOUT_CYC.
module dnoc_itf_out_arb
    import dnoc_out_arb_pkg::*;
#(
    parameter int       NUM_CH      = 4,
    parameter int       FLIT_W      = 256,
    parameter node_id_t NODE_ID     = 4'd0,
    parameter int       SYNC_W      = SYNC_W_DEF,
    parameter int       TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_gnt,
    input  logic [NUM_CH*FLIT_W-1:0] ch_flit,
    input  logic [NUM_CH-1:0]        ch_mc,
    input  logic [NUM_CH*4-1:0]      ch_sync_tid,
    input  logic [NUM_CH*SYNC_W-1:0] ch_sync_target,
    output logic [FLIT_W-1:0]        in_flit,
    output logic                     in_valid,
    output logic                     in_last,
    input  logic                     in_ready,
    output logic                     sync_init,
    output logic [SYNC_W-1:0]        sync_target,
    input  logic                     sync_hit,
    output logic                     busy,
    output logic                     sync_err
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_e          state_r;
    logic [PTR_W-1:0]    rr_ptr_r;
    logic [PTR_W-1:0]    idx_r;
    logic [FLIT_W-1:0]   flit_r;
    logic [SYNC_W-1:0]   target_r;
    logic [FLIT_W-1:0]   in_flit_r;
    logic                in_valid_r;
    logic                sync_init_r;

    logic [NUM_CH-1:0]   pick_onehot_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic                pick_any_s;
    logic [FLIT_W-1:0]   pick_flit_s;
    logic [SYNC_W-1:0]   pick_target_s;
    node_id_t            pick_tid_s;
    logic                pick_mc_s;
    logic                hs_s;
    logic                tmo_s;
    logic [PTR_W-1:0]    next_ptr_s;

    dnoc_rr_pick #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (ch_req),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // AND-OR select of the winning channel's side-band fields
    always_comb begin
        pick_flit_s   = '0;
        pick_target_s = '0;
        pick_tid_s    = '0;
        pick_mc_s     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            pick_flit_s   = pick_flit_s   | ({FLIT_W{pick_onehot_s[i]}} & ch_flit[i*FLIT_W +: FLIT_W]);
            pick_target_s = pick_target_s | ({SYNC_W{pick_onehot_s[i]}} & ch_sync_target[i*SYNC_W +: SYNC_W]);
            pick_tid_s    = pick_tid_s    | ({NODE_ID_W{pick_onehot_s[i]}} & ch_sync_tid[i*4 +: 4]);
            pick_mc_s     = pick_mc_s     | (pick_onehot_s[i] & ch_mc[i]);
        end
    end

    assign hs_s       = in_valid_r & in_ready;
    assign next_ptr_s = (idx_r == PTR_W'(NUM_CH - 1)) ? '0 : idx_r + PTR_W'(1);

    // grant must coincide with the accepting handshake, so it is decoded from it
    always_comb begin
        ch_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_gnt[i] = hs_s & (idx_r == PTR_W'(i));
        end
    end

`ifdef DNOC_OUT_ARB_SYNC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             sync_err_r;

    // counts SYNC cycles; cleared whenever the arbiter is elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_SYNC) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign tmo_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

    // one-cycle error pulse on abandoning a barrier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_r <= 1'b0;
        end else begin
            sync_err_r <= (state_r == ST_SYNC) & ~sync_hit & tmo_s;
        end
    end

    assign sync_err = sync_err_r;
`else
    assign tmo_s    = 1'b0;
    assign sync_err = 1'b0;
`endif

    // main arbitration FSM with registered injection and sync outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            idx_r       <= '0;
            flit_r      <= '0;
            target_r    <= '0;
            in_flit_r   <= '0;
            in_valid_r  <= 1'b0;
            sync_init_r <= 1'b0;
        end else begin
            sync_init_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        idx_r    <= pick_idx_s;
                        flit_r   <= pick_flit_s;
                        target_r <= pick_target_s;
                        if (pick_mc_s && (pick_tid_s == NODE_ID)) begin
                            state_r     <= ST_SYNC;
                            sync_init_r <= 1'b1;
                        end else begin
                            state_r    <= ST_SEND;
                            in_valid_r <= 1'b1;
                            in_flit_r  <= pick_flit_s;
                        end
                    end
                end
                ST_SYNC: begin
                    if (sync_hit) begin
                        state_r    <= ST_SEND;
                        in_valid_r <= 1'b1;
                        in_flit_r  <= flit_r;
                    end else if (tmo_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        state_r    <= ST_IDLE;
                        in_valid_r <= 1'b0;
                        in_flit_r  <= '0;
                        rr_ptr_r   <= next_ptr_s;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_valid_r <= 1'b0;
                    in_flit_r  <= '0;
                end
            endcase
        end
    end

    assign in_flit     = in_flit_r;
    assign in_valid    = in_valid_r;
    assign in_last     = in_valid_r;
    assign sync_init   = sync_init_r;
    assign sync_target = sync_init_r ? target_r : '0;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dnoc_itf_out_arb.sv
// Scoreboard bench for dnoc_itf_out_arb: directed stimulus pushes expected
// grants, sync requests and sync errors; a negedge monitor pops and compares.
module tb_dnoc_itf_out_arb;

    localparam int NUM_CH = 4;
    localparam int FLIT_W = 256;
    localparam int SYNC_W = 12;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH*FLIT_W-1:0] ch_flit;
    logic [NUM_CH-1:0]        ch_mc;
    logic [NUM_CH*4-1:0]      ch_sync_tid;
    logic [NUM_CH*SYNC_W-1:0] ch_sync_target;
    logic [FLIT_W-1:0]        in_flit;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic                     sync_init;
    logic [SYNC_W-1:0]        sync_target;
    logic                     sync_hit;
    logic                     busy;
    logic                     sync_err;

    dnoc_itf_out_arb #(
        .NUM_CH      (NUM_CH),
        .FLIT_W      (FLIT_W),
        .NODE_ID     (4'd0),
        .SYNC_W      (SYNC_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_req         (ch_req),
        .ch_gnt         (ch_gnt),
        .ch_flit        (ch_flit),
        .ch_mc          (ch_mc),
        .ch_sync_tid    (ch_sync_tid),
        .ch_sync_target (ch_sync_target),
        .in_flit        (in_flit),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .sync_init      (sync_init),
        .sync_target    (sync_target),
        .sync_hit       (sync_hit),
        .busy           (busy),
        .sync_err       (sync_err)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                ch;
        logic [FLIT_W-1:0] flit;
        int                at;
    } send_exp_t;

    typedef struct {
        logic [SYNC_W-1:0] target;
        int                at;
    } sync_exp_t;

    send_exp_t send_q[$];
    sync_exp_t sync_q[$];
    int        err_q[$];

    task automatic chk(input string nm, input logic [FLIT_W-1:0] act, input logic [FLIT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [FLIT_W-1:0] flit_pat(input int ch, input logic [7:0] tag);
        logic [31:0] w;
        w = {16'hF1A7, tag, 8'(ch)};
        return {8{w}};
    endfunction

    task automatic push_send(input int ch, input logic [FLIT_W-1:0] f, input int at);
        send_exp_t e;
        e.ch = ch; e.flit = f; e.at = at;
        send_q.push_back(e);
    endtask

    task automatic push_sync(input logic [SYNC_W-1:0] t, input int at);
        sync_exp_t e;
        e.target = t; e.at = at;
        sync_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: every accepted flit, sync request and sync error is matched in order
    always @(negedge clk) begin
        send_exp_t se;
        sync_exp_t ye;
        int        ea;
        chk("in_last", {255'd0, in_last}, {255'd0, in_valid});
        if (in_valid && in_ready) begin
            if (send_q.size() == 0) begin
                chk("unexpected_send", {252'd0, ch_gnt}, 256'd0);
            end else begin
                se = send_q.pop_front();
                chk("gnt_onehot", {252'd0, ch_gnt}, 256'd1 << se.ch);
                chk("gnt_flit", in_flit, se.flit);
                chk("gnt_cycle", 256'(cyc), 256'(se.at));
            end
        end else begin
            chk("no_gnt", {252'd0, ch_gnt}, 256'd0);
            if (!in_valid) chk("flit_zero", in_flit, 256'd0);
        end
        if (sync_init) begin
            if (sync_q.size() == 0) begin
                chk("unexpected_sync_init", 256'd1, 256'd0);
            end else begin
                ye = sync_q.pop_front();
                chk("sync_target", {244'd0, sync_target}, {244'd0, ye.target});
                chk("sync_cycle", 256'(cyc), 256'(ye.at));
            end
        end else begin
            chk("sync_target_idle", {244'd0, sync_target}, 256'd0);
        end
        if (sync_err) begin
            if (err_q.size() == 0) begin
                chk("unexpected_sync_err", 256'd1, 256'd0);
            end else begin
                ea = err_q.pop_front();
                chk("sync_err_cycle", 256'(cyc), 256'(ea));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int p;
        logic [FLIT_W-1:0] flit_a;
        rst_n          = 1'b0;
        ch_req         = '0;
        ch_mc          = '0;
        ch_sync_tid    = '0;
        ch_sync_target = '0;
        in_ready       = 1'b1;
        sync_hit       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) ch_flit[i*FLIT_W +: FLIT_W] = flit_pat(i, 8'h00);

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_in_valid", {255'd0, in_valid}, 256'd0);
        chk("rst_in_flit", in_flit, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_sync_init", {255'd0, sync_init}, 256'd0);
        chk("rst_sync_err", {255'd0, sync_err}, 256'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(2);

        // all four requesting: ch0,1,2,3,0 two cycles apart
        p = cyc;
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) push_send(k % 4, flit_pat(k % 4, 8'h00), p + 1 + 2 * k);
        step(9);
        ch_req = '0;
        step(3);

        // multicast owned by another node: no barrier, one-cycle latency
        ch_mc[1] = 1'b1;
        ch_sync_tid[1*4 +: 4] = 4'h5;
        p = cyc;
        ch_req = 4'b0010;
        push_send(1, flit_pat(1, 8'h00), p + 1);
        step(2);
        ch_req = '0;
        ch_mc = '0;
        ch_sync_tid = '0;
        step(2);

        // locally owned multicast: sync_init, hit at +5, send at +6
        ch_mc[2] = 1'b1;
        ch_sync_target[2*SYNC_W +: SYNC_W] = 12'h0F0;
        ch_sync_target[1*SYNC_W +: SYNC_W] = 12'h123;
        p = cyc;
        ch_req = 4'b0100;
        push_sync(12'h0F0, p + 1);
        push_send(2, flit_pat(2, 8'h00), p + 6);
        step(3);
        chk("sync_busy", {255'd0, busy}, 256'd1);
        chk("sync_no_valid", {255'd0, in_valid}, 256'd0);
        step(2);
        sync_hit = 1'b1;
        step(1);
        sync_hit = 1'b0;
        step(1);
        ch_req = '0;
        ch_mc = '0;
        step(2);

        // reset while sending: pending flit dropped, pointer back to ch0
        p = cyc;
        in_ready = 1'b0;
        ch_req = 4'b1000;
        step(2);
        chk("pre_rst_valid", {255'd0, in_valid}, 256'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {255'd0, in_valid}, 256'd0);
        chk("mid_rst_flit", in_flit, 256'd0);
        chk("mid_rst_busy", {255'd0, busy}, 256'd0);
        step(1);
        rst_n = 1'b1;
        in_ready = 1'b1;
        p = cyc;
        ch_req = 4'b1001;
        push_send(0, flit_pat(0, 8'h00), p + 1);
        push_send(3, flit_pat(3, 8'h00), p + 3);
        step(3);
        ch_req = '0;
        step(2);

        // backpressure: 10 stalled cycles with stable flit, late flit change ignored
        p = cyc;
        in_ready = 1'b0;
        flit_a = flit_pat(3, 8'h5A);
        ch_flit[3*FLIT_W +: FLIT_W] = flit_a;
        ch_req = 4'b1000;
        push_send(3, flit_a, p + 11);
        step(1);
        ch_flit[3*FLIT_W +: FLIT_W] = flit_pat(3, 8'hEE);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", {255'd0, in_valid}, 256'd1);
            chk("stall_flit", in_flit, flit_a);
        end
        @(posedge clk); #1 in_ready = 1'b1;
        step(1);
        ch_req = '0;
        step(2);

`ifdef DNOC_OUT_ARB_SYNC_TIMEOUT_EN
        // barrier never hits: error after 8 SYNC cycles, next channel served
        ch_mc[1] = 1'b1;
        ch_sync_target[1*SYNC_W +: SYNC_W] = 12'h3C3;
        p = cyc;
        ch_req = 4'b0110;
        push_sync(12'h3C3, p + 1);
        err_q.push_back(p + 9);
        push_send(2, flit_pat(2, 8'h00), p + 10);
        step(9);
        ch_req = 4'b0100;
        step(2);
        ch_req = '0;
        ch_mc = '0;
        step(2);
`endif

        for (int w = 0; w < 20 && (send_q.size() != 0 || sync_q.size() != 0 || err_q.size() != 0); w++)
            @(negedge clk);
        chk("send_q_drained", 256'(send_q.size()), 256'd0);
        chk("sync_q_drained", 256'(sync_q.size()), 256'd0);
        chk("err_q_drained", 256'(err_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
